// File: rtl/dijkstra_pkg.sv
// Shared types and constants for the Dijkstra datapath: infinity encoding,
// command op codes, visited-bit polarity and the distance queue FSM states.
package dijkstra_pkg;

  localparam logic VISITED   = 1'b1;
  localparam logic UNVISITED = 1'b0;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_RELAX = 2'b10
  } op_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } queue_state_e;

  // All-ones value of the given width; callers cast down to their width.
  function automatic logic [31:0] infinity(input int unsigned width);
    logic [31:0] result;
    result = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(width)) result[i] = 1'b1;
    end
    return result;
  endfunction

endpackage

// File: rtl/min_lane_reducer.sv
// Folds one scan beat of lanes into the running minimum. Visited and INFINITY
// entries are skipped; lanes are visited in ascending index order.
module min_lane_reducer
  import dijkstra_pkg::*;
#(
  parameter int LANES       = 2,
  parameter int INDEX_WIDTH = 3,
  parameter int VALUE_WIDTH = 8
) (
  input  logic [LANES*VALUE_WIDTH-1:0] lane_values,
  input  logic [LANES*INDEX_WIDTH-1:0] lane_indices,
  input  logic [LANES-1:0]             lane_visited,
  input  logic [VALUE_WIDTH-1:0]       best_value,
  input  logic [INDEX_WIDTH-1:0]       best_index,
  input  logic                         best_found,
  output logic [VALUE_WIDTH-1:0]       new_value,
  output logic [INDEX_WIDTH-1:0]       new_index,
  output logic                         new_found
);

  localparam logic [VALUE_WIDTH-1:0] INF = VALUE_WIDTH'(infinity(VALUE_WIDTH));

  logic [VALUE_WIDTH-1:0] cand;
  logic                   eligible;

  // Strict less-than: an equal value in a later lane never displaces the
  // current best, so ties resolve to the lowest index.
  always_comb begin
    new_value = best_value;
    new_index = best_index;
    new_found = best_found;
    cand      = '0;
    eligible  = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      cand     = lane_values[l*VALUE_WIDTH +: VALUE_WIDTH];
      eligible = (lane_visited[l] != VISITED) && (cand != INF);
      if (eligible && (!new_found || (cand < new_value))) begin
        new_value = cand;
        new_index = lane_indices[l*INDEX_WIDTH +: INDEX_WIDTH];
        new_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/distance_queue.sv
// Tentative-distance store for Dijkstra with write/relax commands and a
// multi-cycle minimum search over unvisited entries, SCAN_LANES per beat.
module distance_queue
  import dijkstra_pkg::*;
#(
  parameter int MAX_NODES    = 8,
  parameter int INDEX_WIDTH  = $clog2(MAX_NODES),
  parameter int VALUE_WIDTH  = 8,
  parameter int SCAN_LANES   = 2,
  parameter int SOURCE_INDEX = 0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic [INDEX_WIDTH-1:0] source,
  input  logic                   op_valid,
  output logic                   op_ready,
  input  logic [1:0]             op_code,
  input  logic [INDEX_WIDTH-1:0] op_index,
  input  logic [VALUE_WIDTH-1:0] op_value,
  output logic                   relax_updated,
  input  logic [INDEX_WIDTH-1:0] read_index,
  output logic [VALUE_WIDTH-1:0] read_value,
  input  logic [MAX_NODES-1:0]   visited_vector,
  input  logic                   find_req,
  output logic                   find_busy,
  output logic                   find_done,
  output logic [INDEX_WIDTH-1:0] min_index,
  output logic [VALUE_WIDTH-1:0] min_value,
  output logic                   min_empty,
  output logic [1:0]             fsm_state
);

  localparam int BEATS      = MAX_NODES / SCAN_LANES;
  localparam int BEAT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [VALUE_WIDTH-1:0] INF = VALUE_WIDTH'(infinity(VALUE_WIDTH));
  localparam logic [BEAT_WIDTH-1:0]  LAST_BEAT = BEAT_WIDTH'(BEATS - 1);

  queue_state_e state, state_next;

  logic [VALUE_WIDTH-1:0] entries [MAX_NODES];
  logic [BEAT_WIDTH-1:0]  beat;
  logic [VALUE_WIDTH-1:0] best_value;
  logic [INDEX_WIDTH-1:0] best_index;
  logic                   best_found;

  logic [SCAN_LANES*VALUE_WIDTH-1:0] lane_values;
  logic [SCAN_LANES*INDEX_WIDTH-1:0] lane_indices;
  logic [SCAN_LANES-1:0]             lane_visited;
  logic [INDEX_WIDTH-1:0]            lane_pos [SCAN_LANES];

  logic [VALUE_WIDTH-1:0] red_value;
  logic [INDEX_WIDTH-1:0] red_index;
  logic                   red_found;

  logic accept;
  logic relax_lower;
  logic scan_last;

  // Command handshake: a command transfers on a rising edge where op_valid and
  // op_ready are both high; the requester holds op_valid and the payload
  // stable until then. op_ready is high only in IDLE; clear blocks transfer.
  assign op_ready    = (state == ST_IDLE);
  assign accept      = op_valid && op_ready && !clear;
  assign relax_lower = (op_value < entries[op_index]);
  assign find_busy   = (state == ST_SCAN);
  assign find_done   = (state == ST_DONE);
  assign scan_last   = (state == ST_SCAN) && (beat == LAST_BEAT);
  assign fsm_state   = state;

  always_comb begin
    lane_values  = '0;
    lane_indices = '0;
    lane_visited = '0;
    for (int l = 0; l < SCAN_LANES; l++) begin
      lane_pos[l] = INDEX_WIDTH'(int'(beat) * SCAN_LANES + l);
      lane_values[l*VALUE_WIDTH +: VALUE_WIDTH]  = entries[lane_pos[l]];
      lane_indices[l*INDEX_WIDTH +: INDEX_WIDTH] = lane_pos[l];
      lane_visited[l] = visited_vector[lane_pos[l]];
    end
  end

  min_lane_reducer #(
    .LANES      (SCAN_LANES),
    .INDEX_WIDTH(INDEX_WIDTH),
    .VALUE_WIDTH(VALUE_WIDTH)
  ) u_reducer (
    .lane_values (lane_values),
    .lane_indices(lane_indices),
    .lane_visited(lane_visited),
    .best_value  (best_value),
    .best_index  (best_index),
    .best_found  (best_found),
    .new_value   (red_value),
    .new_index   (red_index),
    .new_found   (red_found)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (find_req) state_next = ST_SCAN;
      ST_SCAN: if (beat == LAST_BEAT) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (clear) state_next = ST_IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_NODES; i++) begin
        entries[i] <= (i == SOURCE_INDEX) ? '0 : INF;
      end
    end else if (clear) begin
      for (int i = 0; i < MAX_NODES; i++) begin
        entries[i] <= (INDEX_WIDTH'(i) == source) ? '0 : INF;
      end
    end else if (accept) begin
      case (op_code_e'(op_code))
        OP_WRITE: entries[op_index] <= op_value;
        OP_RELAX: if (relax_lower) entries[op_index] <= op_value;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_value    <= '0;
      relax_updated <= 1'b0;
    end else begin
      read_value    <= entries[read_index];
      relax_updated <= accept && (op_code == OP_RELAX) && relax_lower;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beat       <= '0;
      best_value <= INF;
      best_index <= '0;
      best_found <= 1'b0;
      min_index  <= '0;
      min_value  <= INF;
      min_empty  <= 1'b1;
    end else if (!clear) begin
      if ((state == ST_IDLE) && find_req) begin
        beat       <= '0;
        best_value <= INF;
        best_index <= '0;
        best_found <= 1'b0;
      end else if (state == ST_SCAN) begin
        beat       <= beat + BEAT_WIDTH'(1);
        best_value <= red_value;
        best_index <= red_index;
        best_found <= red_found;
      end
      // Result lands on the edge entering DONE so it is valid with find_done.
      if (scan_last) begin
        min_index <= red_found ? red_index : '0;
        min_value <= red_found ? red_value : INF;
        min_empty <= !red_found;
      end
    end
  end

endmodule

// File: tb/tb_distance_queue.sv
// Directed bench for distance_queue: command/read vector table plus
// hand-written find, busy, clear and reset sequences.
module tb_distance_queue;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam int VW = 8;

  logic          clock;
  logic          reset_n;
  logic          clear;
  logic [IW-1:0] source;
  logic          op_valid;
  logic          op_ready;
  logic [1:0]    op_code;
  logic [IW-1:0] op_index;
  logic [VW-1:0] op_value;
  logic          relax_updated;
  logic [IW-1:0] read_index;
  logic [VW-1:0] read_value;
  logic [N-1:0]  visited_vector;
  logic          find_req;
  logic          find_busy;
  logic          find_done;
  logic [IW-1:0] min_index;
  logic [VW-1:0] min_value;
  logic          min_empty;
  logic [1:0]    fsm_state;

  int checks = 0;
  int errors = 0;
  logic [VW-1:0] exp_q[$];

  distance_queue #(
    .MAX_NODES(N), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW), .SCAN_LANES(2), .SOURCE_INDEX(0)
  ) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .source(source),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_index(op_index), .op_value(op_value), .relax_updated(relax_updated),
    .read_index(read_index), .read_value(read_value),
    .visited_vector(visited_vector), .find_req(find_req),
    .find_busy(find_busy), .find_done(find_done), .min_index(min_index),
    .min_value(min_value), .min_empty(min_empty), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]    code;
    logic [IW-1:0] idx;
    logic [VW-1:0] val;
    logic          exp_upd;
    logic [VW-1:0] exp_entry;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic issue_cmd(input logic [1:0] code, input logic [IW-1:0] idx, input logic [VW-1:0] val);
    @(negedge clock);
    op_valid = 1'b1; op_code = code; op_index = idx; op_value = val;
    @(negedge clock);
    op_valid = 1'b0; op_code = 2'b00;
  endtask

  task automatic read_entry(input logic [IW-1:0] idx, output logic [VW-1:0] v);
    @(negedge clock);
    read_index = idx;
    @(negedge clock);
    v = read_value;
  endtask

  task automatic read_sweep(input string name);
    logic [VW-1:0] v;
    for (int i = 0; i < N; i++) begin
      read_entry(IW'(i), v);
      check(name, {24'd0, v}, {24'd0, exp_q.pop_front()});
    end
  endtask

  task automatic run_find(input string name, input logic [IW-1:0] e_idx,
                          input logic [VW-1:0] e_val, input logic e_empty);
    int cycles;
    @(negedge clock);
    find_req = 1'b1;
    @(negedge clock);
    find_req = 1'b0;
    cycles = 1;
    check({name, "_busy"}, {31'd0, find_busy}, 32'd1);
    while (!find_done && cycles < 20) begin
      @(negedge clock);
      cycles++;
    end
    check({name, "_latency"}, cycles, 32'd5);
    check({name, "_busy_at_done"}, {31'd0, find_busy}, 32'd0);
    check({name, "_ready_at_done"}, {31'd0, op_ready}, 32'd0);
    check({name, "_index"}, {29'd0, min_index}, {29'd0, e_idx});
    check({name, "_value"}, {24'd0, min_value}, {24'd0, e_val});
    check({name, "_empty"}, {31'd0, min_empty}, {31'd0, e_empty});
    @(negedge clock);
    check({name, "_done_pulse"}, {31'd0, find_done}, 32'd0);
    check({name, "_ready_after"}, {31'd0, op_ready}, 32'd1);
  endtask

  // Command vector: accept, check the relax pulse and its fall, read back.
  task automatic apply_vec(input int i);
    logic [VW-1:0] v;
    issue_cmd(vecs[i].code, vecs[i].idx, vecs[i].val);
    check($sformatf("vec%0d_upd", i), {31'd0, relax_updated}, {31'd0, vecs[i].exp_upd});
    @(negedge clock);
    check($sformatf("vec%0d_upd_fall", i), {31'd0, relax_updated}, 32'd0);
    read_entry(vecs[i].idx, v);
    check($sformatf("vec%0d_entry", i), {24'd0, v}, {24'd0, vecs[i].exp_entry});
  endtask

  initial begin
    int cycles;
    int ready_seen;
    int busy_seen;
    int done_seen;
    logic [VW-1:0] v;

    vecs[0] = '{2'b01, 3'd0, 8'd255, 1'b0, 8'd255};
    vecs[1] = '{2'b01, 3'd3, 8'd20,  1'b0, 8'd20};
    vecs[2] = '{2'b01, 3'd5, 8'd20,  1'b0, 8'd20};
    vecs[3] = '{2'b01, 3'd6, 8'd7,   1'b0, 8'd7};
    vecs[4] = '{2'b10, 3'd3, 8'd30,  1'b0, 8'd20};
    vecs[5] = '{2'b10, 3'd3, 8'd10,  1'b1, 8'd10};
    vecs[6] = '{2'b10, 3'd1, 8'd40,  1'b1, 8'd40};
    vecs[7] = '{2'b11, 3'd5, 8'd1,   1'b0, 8'd20};
    vecs[8] = '{2'b00, 3'd6, 8'd1,   1'b0, 8'd7};
    vecs[9] = '{2'b10, 3'd6, 8'd7,   1'b0, 8'd7};

    reset_n = 1'b0; clear = 1'b0; source = '0;
    op_valid = 1'b0; op_code = 2'b00; op_index = '0; op_value = '0;
    read_index = '0; visited_vector = '0; find_req = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    check("rst_read_value", {24'd0, read_value}, 32'd0);
    check("rst_min_index", {29'd0, min_index}, 32'd0);
    check("rst_min_value", {24'd0, min_value}, 32'd255);
    check("rst_min_empty", {31'd0, min_empty}, 32'd1);
    check("rst_find_busy", {31'd0, find_busy}, 32'd0);
    check("rst_find_done", {31'd0, find_done}, 32'd0);
    check("rst_relax_updated", {31'd0, relax_updated}, 32'd0);
    check("rst_op_ready", {31'd0, op_ready}, 32'd1);
    check("rst_state", {30'd0, fsm_state}, 32'd0);

    exp_q.push_back(8'd0);
    repeat (7) exp_q.push_back(8'd255);
    read_sweep("rst_entry");
    run_find("find_reset", 3'd0, 8'd0, 1'b0);

    for (int i = 0; i < 4; i++) apply_vec(i);
    visited_vector = 8'h40;
    run_find("find_tie", 3'd3, 8'd20, 1'b0);

    for (int i = 4; i < 10; i++) apply_vec(i);
    run_find("find_relaxed", 3'd3, 8'd10, 1'b0);
    visited_vector = 8'h08;
    run_find("find_last_beat", 3'd6, 8'd7, 1'b0);
    visited_vector = 8'hFF;
    run_find("find_all_visited", 3'd0, 8'd255, 1'b1);

    // Write and a second find presented during a scan.
    visited_vector = 8'h00;
    @(negedge clock);
    find_req = 1'b1;
    @(negedge clock);
    op_valid = 1'b1; op_code = 2'b01; op_index = 3'd2; op_value = 8'd9;
    check("busy_ready_low", {31'd0, op_ready}, 32'd0);
    cycles = 1;
    ready_seen = 0;
    while (!find_done && cycles < 20) begin
      @(negedge clock);
      cycles++;
      if (cycles == 3) find_req = 1'b0;
      if (op_ready) ready_seen++;
    end
    check("busy_latency", cycles, 32'd5);
    check("busy_ready_seen", ready_seen, 32'd0);
    check("busy_min_index", {29'd0, min_index}, 32'd6);
    check("busy_min_value", {24'd0, min_value}, 32'd7);
    @(negedge clock);
    check("busy_ready_after", {31'd0, op_ready}, 32'd1);
    check("busy_second_find_ignored", {31'd0, find_busy}, 32'd0);
    @(negedge clock);
    op_valid = 1'b0; op_code = 2'b00;
    busy_seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (find_busy || find_done) busy_seen++;
    end
    check("busy_no_second_scan", busy_seen, 32'd0);
    read_entry(3'd2, v);
    check("busy_write_entry", {24'd0, v}, 32'd9);

    // clear at scan beat 2
    @(negedge clock);
    find_req = 1'b1;
    @(negedge clock);
    find_req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    clear = 1'b1; source = 3'd4;
    @(negedge clock);
    clear = 1'b0;
    check("clear_busy", {31'd0, find_busy}, 32'd0);
    check("clear_ready", {31'd0, op_ready}, 32'd1);
    done_seen = 0;
    repeat (8) begin
      @(negedge clock);
      if (find_done) done_seen++;
    end
    check("clear_no_done", done_seen, 32'd0);
    check("clear_min_index_held", {29'd0, min_index}, 32'd6);
    check("clear_min_value_held", {24'd0, min_value}, 32'd7);
    check("clear_min_empty_held", {31'd0, min_empty}, 32'd0);
    repeat (4) exp_q.push_back(8'd255);
    exp_q.push_back(8'd0);
    repeat (3) exp_q.push_back(8'd255);
    read_sweep("clear_entry");

    // reset at scan beat 1
    issue_cmd(2'b01, 3'd0, 8'd5);
    read_entry(3'd0, v);
    check("pre_reset_entry0", {24'd0, v}, 32'd5);
    @(negedge clock);
    find_req = 1'b1;
    @(negedge clock);
    find_req = 1'b0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, find_busy}, 32'd0);
    check("midrst_done", {31'd0, find_done}, 32'd0);
    check("midrst_ready", {31'd0, op_ready}, 32'd1);
    check("midrst_read_value", {24'd0, read_value}, 32'd0);
    check("midrst_min_index", {29'd0, min_index}, 32'd0);
    check("midrst_min_value", {24'd0, min_value}, 32'd255);
    check("midrst_min_empty", {31'd0, min_empty}, 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    read_entry(3'd0, v);
    check("postrst_entry0", {24'd0, v}, 32'd0);
    read_entry(3'd4, v);
    check("postrst_entry4", {24'd0, v}, 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
